mem_stage: RTL

// - Pipeline stage directly downstream of the ALU. It consumes the ALU result, the effective address, the

---
 rtl/mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Purpose
//   Pipeline stage placed directly after the ALU. Non-memory ops are handed
//   to writeback one cycle after acceptance. Loads and stores are turned into
//   a single valid/ready data-memory request. The stage then waits for the
//   response or store ack. Load data is lane-aligned and sign- or
//   zero-extended before it is handed to writeback. A response timeout
//   reports a bus error instead of hanging the pipeline.
//
// Handshake rules
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A valid source holds its payload unchanged until that edge. in_ready
//   and dreq_valid come straight from the state register, so neither one
//   depends combinationally on the other side's valid or ready.
//
// Ports
//   clk, reset       clock; synchronous active-low reset
//   in_valid/ready   op handshake from the ALU (in_ready is 1 only in IDLE)
//   in_pc, in_rd     PC and destination register carried with the op
//   in_data          ALU result / load address / store data
//   in_addr          store address
//   in_is_load/store memory op kind; in_size 0=B 1=H 2=W 3=D
//   in_unsigned      zero-extend load data
//   dreq_*           data-memory request (8-byte aligned address, replicated
//                    write data, byte strobes)
//   dresp_valid/data response or store ack, 8-byte aligned read data
//   o_valid          single-cycle completion pulse to writeback, with
//                    o_pc, o_data, o_rd, o_wr_en, o_bus_err
//   o_dbg_state      current FSM state, for debug visibility
//
// Configuration
//   MEM_MISALIGN_TRAP_EN  when defined, a misaligned H/W/D access issues no
//                         request. It completes one cycle after acceptance
//                         with o_bus_err=1. When undefined, the low address
//                         bits are used as given and strobe bits shifted
//                         past bit 7 are dropped.
// ---------------------------------------------------------------------------
module mem_stage #(
   parameter int XLEN         = 64,
   parameter int PC_W         = 32,
   parameter int RESP_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic [XLEN-1:0] in_data,
   input  logic [XLEN-1:0] in_addr,
   input  logic [4:0]      in_rd,
   input  logic            in_is_load,
   input  logic            in_is_store,
   input  logic [1:0]      in_size,
   input  logic            in_unsigned,
   output logic            dreq_valid,
   input  logic            dreq_ready,
   output logic [XLEN-1:0] dreq_addr,
   output logic            dreq_we,
   output logic [XLEN-1:0] dreq_wdata,
   output logic [7:0]      dreq_wstrb,
   input  logic            dresp_valid,
   input  logic [XLEN-1:0] dresp_data,
   output logic            o_valid,
   output logic [PC_W-1:0] o_pc,
   output logic [XLEN-1:0] o_data,
   output logic [4:0]      o_rd,
   output logic            o_wr_en,
   output logic            o_bus_err,
   output logic [1:0]      o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // The counter holds the number of WAIT cycles already spent without a
   // response. Timing out when it equals RESP_TIMEOUT-1 makes the error pulse
   // appear exactly RESP_TIMEOUT cycles after WAIT is entered.
   localparam logic [7:0] TO_LAST = 8'(RESP_TIMEOUT - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [7:0]        r_cnt;
   logic [7:0]        w_cnt_next;

   // Op latched on acceptance of a memory op
   logic [PC_W-1:0]   r_pc;
   logic [4:0]        r_rd;
   logic              r_is_store;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [2:0]        r_lane;
   logic [XLEN-1:0]   r_dreq_addr;
   logic              r_dreq_we;
   logic [XLEN-1:0]   r_wdata;
   logic [7:0]        r_wstrb;

   // Registered completion outputs
   logic              r_out_valid;
   logic [PC_W-1:0]   r_out_pc;
   logic [XLEN-1:0]   r_out_data;
   logic [4:0]        r_out_rd;
   logic              r_out_wr_en;
   logic              r_out_err;

   // Combinational helpers
   logic              w_accept;
   logic              w_in_mem;
   logic [XLEN-1:0]   w_in_addr;
   logic [7:0]        w_size_mask;
   logic [7:0]        w_in_wstrb;
   logic [XLEN-1:0]   w_in_wdata;
   logic              w_misalign;
   logic [XLEN-1:0]   w_load_shift;
   logic [XLEN-1:0]   w_load_val;

   logic              w_done_valid;
   logic [PC_W-1:0]   w_done_pc;
   logic [XLEN-1:0]   w_done_data;
   logic [4:0]        w_done_rd;
   logic              w_done_wr_en;
   logic              w_done_err;

   assign in_ready    = (r_state == S_IDLE);
   assign dreq_valid  = (r_state == S_REQ);
   assign dreq_addr   = r_dreq_addr;
   assign dreq_we     = r_dreq_we;
   assign dreq_wdata  = r_wdata;
   assign dreq_wstrb  = r_wstrb;
   assign o_valid     = r_out_valid;
   assign o_pc        = r_out_pc;
   assign o_data      = r_out_data;
   assign o_rd        = r_out_rd;
   assign o_wr_en     = r_out_wr_en;
   assign o_bus_err   = r_out_err;
   assign o_dbg_state = r_state;

   assign w_accept = in_valid & in_ready;
   assign w_in_mem = in_is_load | in_is_store;

   // Request formation from the incoming op. A load takes its address from
   // in_data. A store takes its address from in_addr and its data from
   // in_data.
   always_comb begin
      w_in_addr   = in_is_store ? in_addr : in_data;
      w_size_mask = 8'h01;
      w_in_wdata  = '0;
      case (in_size)
         2'd0: w_size_mask = 8'h01;
         2'd1: w_size_mask = 8'h03;
         2'd2: w_size_mask = 8'h0F;
         default: w_size_mask = 8'hFF;
      endcase
      // The shift stays 8 bits wide, so enables beyond lane 7 fall off.
      w_in_wstrb = w_size_mask << w_in_addr[2:0];
      if (in_is_store) begin
         case (in_size)
            2'd0: w_in_wdata = {(XLEN/8){in_data[7:0]}};
            2'd1: w_in_wdata = {(XLEN/16){in_data[15:0]}};
            2'd2: w_in_wdata = {(XLEN/32){in_data[31:0]}};
            default: w_in_wdata = in_data;
         endcase
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      w_misalign = 1'b0;
      case (in_size)
         2'd1: w_misalign = w_in_addr[0];
         2'd2: w_misalign = |w_in_addr[1:0];
         2'd3: w_misalign = |w_in_addr[2:0];
         default: w_misalign = 1'b0;
      endcase
   end
`else
   assign w_misalign = 1'b0;
`endif

   // Load alignment: move the addressed lane down to bit 0, then extend.
   // A shift, rather than a part-select, zero-fills any bytes past the top
   // of the beat.
   assign w_load_shift = dresp_data >> {r_lane, 3'b000};

   always_comb begin
      w_load_val = dresp_data;
      case (r_size)
         2'd0: w_load_val = r_unsigned ? {{(XLEN-8){1'b0}}, w_load_shift[7:0]}
                                       : {{(XLEN-8){w_load_shift[7]}}, w_load_shift[7:0]};
         2'd1: w_load_val = r_unsigned ? {{(XLEN-16){1'b0}}, w_load_shift[15:0]}
                                       : {{(XLEN-16){w_load_shift[15]}}, w_load_shift[15:0]};
         2'd2: w_load_val = r_unsigned ? {{(XLEN-32){1'b0}}, w_load_shift[31:0]}
                                       : {{(XLEN-32){w_load_shift[31]}}, w_load_shift[31:0]};
         default: w_load_val = dresp_data;
      endcase
   end

   // Next-state and completion logic
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_done_valid = 1'b0;
      w_done_pc    = '0;
      w_done_data  = '0;
      w_done_rd    = '0;
      w_done_wr_en = 1'b0;
      w_done_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_in_mem) begin
                  w_done_valid = 1'b1;
                  w_done_pc    = in_pc;
                  w_done_data  = in_data;
                  w_done_rd    = in_rd;
                  w_done_wr_en = (in_rd != 5'd0);
               end else if (w_misalign) begin
                  w_done_valid = 1'b1;
                  w_done_pc    = in_pc;
                  w_done_rd    = in_rd;
                  w_done_err   = 1'b1;
               end else begin
                  w_next_state = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (dreq_ready) begin
               w_next_state = S_WAIT;
               w_cnt_next   = 8'd0;
            end
         end
         S_WAIT: begin
            // A response in the last allowed cycle beats the timeout.
            if (dresp_valid) begin
               w_next_state = S_IDLE;
               w_cnt_next   = 8'd0;
               w_done_valid = 1'b1;
               w_done_pc    = r_pc;
               w_done_rd    = r_rd;
               w_done_data  = r_is_store ? '0 : w_load_val;
               w_done_wr_en = !r_is_store && (r_rd != 5'd0);
            end else if (r_cnt == TO_LAST) begin
               w_next_state = S_IDLE;
               w_cnt_next   = 8'd0;
               w_done_valid = 1'b1;
               w_done_pc    = r_pc;
               w_done_rd    = r_rd;
               w_done_err   = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt       <= 8'd0;
         r_pc        <= '0;
         r_rd        <= '0;
         r_is_store  <= 1'b0;
         r_size      <= 2'd0;
         r_unsigned  <= 1'b0;
         r_lane      <= 3'd0;
         r_dreq_addr <= '0;
         r_dreq_we   <= 1'b0;
         r_wdata     <= '0;
         r_wstrb     <= 8'd0;
         r_out_valid <= 1'b0;
         r_out_pc    <= '0;
         r_out_data  <= '0;
         r_out_rd    <= '0;
         r_out_wr_en <= 1'b0;
         r_out_err   <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_accept && w_in_mem) begin
            r_pc        <= in_pc;
            r_rd        <= in_rd;
            r_is_store  <= in_is_store;
            r_size      <= in_size;
            r_unsigned  <= in_unsigned;
            r_lane      <= w_in_addr[2:0];
            r_dreq_addr <= {w_in_addr[XLEN-1:3], 3'b000};
            r_dreq_we   <= in_is_store;
            r_wdata     <= w_in_wdata;
            r_wstrb     <= w_in_wstrb;
         end
         r_out_valid <= w_done_valid;
         r_out_pc    <= w_done_pc;
         r_out_data  <= w_done_data;
         r_out_rd    <= w_done_rd;
         r_out_wr_en <= w_done_wr_en;
         r_out_err   <= w_done_err;
      end
   end

endmodule
